// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier datapath.
// The state encoding, iteration count and working-register widths are defined here.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MULT_ITER = 16;
    localparam int ACC_W     = 34;
    localparam int DATA_W    = 32;
    // Working register layout: {acc, mplr, guard}
    localparam int P_W       = ACC_W + DATA_W + 1;
    localparam int CNT_W     = $clog2(MULT_ITER);

    // Sign-extend a multiplicand into the accumulator width.
    function automatic logic [ACC_W-1:0] sext_m(input logic [DATA_W-1:0] a);
        return {{(ACC_W - DATA_W){a[DATA_W-1]}}, a};
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 modified Booth recoder: maps the multiplier triplet and the multiplicand M
// to the 34-bit addend (0, +-M, +-2M), all modulo 2^34.
module booth_recode
    import mult_pkg::*;
(
    input  logic [2:0]       triplet,
    input  logic [ACC_W-1:0] m,
    output logic [ACC_W-1:0] addend
);

    logic [ACC_W-1:0] m2;

    assign m2 = m << 1;

    // NOTE: addend gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        addend = '0;
        case (triplet)
            3'b001, 3'b010: addend = m;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m;
            default:        addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed 32x32 multiplier, radix-4 Booth, one partial product per cycle.
// Presents the low product word, the sign-correct upper slice and the latched operands.
module booth_mult
    import mult_pkg::*;
#(
    parameter int ITER = MULT_ITER
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ctrl_MULT,
    input  logic [DATA_W-1:0]   data_operandA,
    input  logic [DATA_W-1:0]   data_operandB,
    output logic [DATA_W-1:0]   data_result,
    output logic [ACC_W-1:0]    hi,
    output logic [DATA_W-1:0]   a_q,
    output logic [DATA_W-1:0]   b_q,
    output logic                busy,
    output logic                data_resultRDY
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [P_W-1:0]      p_q, p_d;
    logic [DATA_W-1:0]   a_d, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [ACC_W-1:0]    hi_q, hi_d;
    logic                busy_q, busy_d;
    logic                rdy_q, rdy_d;

    logic [ACC_W-1:0]    m;
    logic [ACC_W-1:0]    addend;
    logic [ACC_W-1:0]    acc_sum;
    logic [P_W-1:0]      p_shift;

    assign m = sext_m(a_q);

    booth_recode u_recode (
        .triplet (p_q[2:0]),
        .m       (m),
        .addend  (addend)
    );

    // Add into the accumulator, then arithmetic-shift the whole working register by two.
    assign acc_sum = p_q[P_W-1 -: ACC_W] + addend;
    assign p_shift = {{2{acc_sum[ACC_W-1]}}, acc_sum, p_q[DATA_W:2]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        hi_d     = hi_q;

        case (state_q)
            IDLE, DONE: begin
                if (ctrl_MULT) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    p_d     = {{ACC_W{1'b0}}, data_operandB, 1'b0};
                    a_d     = data_operandA;
                    b_d     = data_operandB;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = p_shift[DATA_W:1];
                    hi_d     = p_shift[P_W-1:DATA_W+1];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        rdy_d  = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            hi_q     <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign hi             = hi_q;
    assign busy           = busy_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: stimulus pushes expected products computed with plain
// signed arithmetic; a negedge monitor pops and compares on every data_resultRDY pulse.
module tb_booth_mult;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [33:0] hi;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        busy;
    logic        data_resultRDY;

    booth_mult dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .hi             (hi),
        .a_q            (a_q),
        .b_q            (b_q),
        .busy           (busy),
        .data_resultRDY (data_resultRDY)
    );

    typedef struct {
        logic [31:0] lo;
        logic [33:0] hi;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_start = -100;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: full signed product, sign-extended to 66 bits.
    function automatic logic [65:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        int    sa = a;
        int    sb = b;
        longint p = longint'(sa) * longint'(sb);
        return {{2{p[63]}}, p};
    endfunction

    // Called just after a negedge: present a start, let the edge take it, drop it at the next negedge.
    // A start is accepted when no operation is in flight or when it lands on the DONE cycle.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                            input bit use_exp, input logic [31:0] exp_lo, input logic [33:0] exp_hi);
        int   s;
        exp_t e;
        logic [65:0] p;
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        s = cyc + 1;
        if (s - last_start >= 17) begin
            p    = ref_prod(a, b);
            e.lo = use_exp ? exp_lo : p[31:0];
            e.hi = use_exp ? exp_hi : p[65:32];
            e.a  = a;
            e.b  = b;
            e.cyc = s + 16;
            sb_q.push_back(e);
            last_start = s;
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Monitor: compares every ready pulse against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            check("rdy_busy_exclusive", {65'd0, busy}, 66'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_rdy", 66'd1, 66'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data_result", {34'd0, data_result}, {34'd0, e.lo});
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("a_q", {34'd0, a_q}, {34'd0, e.a});
                check("b_q", {34'd0, b_q}, {34'd0, e.b});
                check("rdy_cycle", 66'(cyc), 66'(e.cyc));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, {34'd0, data_result}, 66'd0);
        check({tag, "_hi"}, {32'd0, hi}, 66'd0);
        check({tag, "_a_q"}, {34'd0, a_q}, 66'd0);
        check({tag, "_b_q"}, {34'd0, b_q}, 66'd0);
        check({tag, "_busy_rdy"}, {64'd0, busy, data_resultRDY}, 66'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Directed products from hand-derived values.
        do_start(32'd3, 32'd4, 1'b1, 32'h0000000C, 34'h0);
        check("busy_after_start", {65'd0, busy}, 66'd1);
        repeat (18) @(negedge clock);
        do_start(32'hFFFFFFFD, 32'd4, 1'b1, 32'hFFFFFFF4, 34'h3_FFFF_FFFF);
        repeat (18) @(negedge clock);
        do_start(32'h7FFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFE, 34'h0);
        repeat (18) @(negedge clock);
        do_start(32'h80000000, 32'h80000000, 1'b1, 32'h0, 34'h0_4000_0000);
        repeat (18) @(negedge clock);

        // A start while running must be ignored.
        do_start(32'd5, 32'd6, 1'b1, 32'd30, 34'h0);
        repeat (4) @(negedge clock);
        do_start(32'd9, 32'd9, 1'b0, 32'd0, 34'h0);
        check("ignored_start_a_q", {34'd0, a_q}, 66'd5);
        check("ignored_start_b_q", {34'd0, b_q}, 66'd6);
        repeat (20) @(negedge clock);

        // Back-to-back: second start lands on the DONE cycle; result holds during the next op.
        do_start(32'd7, 32'd7, 1'b1, 32'd49, 34'h0);
        repeat (16) @(negedge clock);
        do_start(32'd11, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFEA, 34'h3_FFFF_FFFF);
        repeat (3) @(negedge clock);
        check("hold_result", {34'd0, data_result}, 66'd49);
        check("new_a_q", {34'd0, a_q}, 66'd11);
        repeat (16) @(negedge clock);

        // Reset mid-operation aborts with no ready pulse.
        do_start(32'd123, 32'd456, 1'b1, 32'd56088, 34'h0);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        sb_q.delete();
        last_start = -100;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        do_start(32'hFFFFFF00, 32'hFFFFFF00, 1'b1, 32'h00010000, 34'h0);
        repeat (18) @(negedge clock);

        // Randomized operands with random gaps (gap 0 = start in the DONE cycle).
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'h80000000;
                2: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            do_start(ra, rb, 1'b0, 32'd0, 34'h0);
            repeat (16 + $urandom_range(0, 3)) @(negedge clock);
        end

        for (int t = 0; t < 40 && sb_q.size() > 0; t++) @(negedge clock);
        check("scoreboard_drained", 66'(sb_q.size()), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
